// File: rtl/mem_copy_dma.sv
// mem_copy_dma: byte-serial memory-to-memory copy engine with an optional fill mode.
// A copy moves each byte in two cycles: READ latches the source byte, then WRITE stores it.
// Define DMA_FILL_EN to enable fill mode: FillValue is written to Len bytes, one per cycle.
// Without DMA_FILL_EN, Fill and FillValue are ignored and every transfer is a copy.
//
// state   | meaning
// S_IDLE  | waiting for Start; memory port quiet
// S_READ  | source byte on MemRData, latched into holding register
// S_WRITE | holding register (or fill byte) written to destination
// S_DONE  | one-cycle completion pulse
module mem_copy_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Len,
  input  logic              Fill,
  input  logic [DATA_W-1:0] FillValue,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Remaining,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWriteEn,
  input  logic [DATA_W-1:0] MemRData
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_rem;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_fill_val;
  logic              r_fill;
  logic              w_fill_req;
  logic              w_accept;

`ifdef DMA_FILL_EN
  assign w_fill_req = Fill;
`else
  // Fill is tied off so the fill path folds away and every transfer copies.
  assign w_fill_req = Fill & 1'b0;
`endif

  assign w_accept  = (r_state == S_IDLE) && Start && (Len != '0);
  assign Remaining = r_rem;

  // State register; reset aborts any transfer without resuming it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and memory-port outputs, all derived from the current state.
  always_comb begin
    w_next     = r_state;
    Busy       = 1'b0;
    Done       = 1'b0;
    MemAddr    = '0;
    MemWData   = '0;
    MemWriteEn = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (Len == '0)      w_next = S_DONE;
          else if (w_fill_req) w_next = S_WRITE;
          else                w_next = S_READ;
        end
      end
      S_READ: begin
        Busy    = 1'b1;
        MemAddr = r_src;
        w_next  = S_WRITE;
      end
      S_WRITE: begin
        Busy       = 1'b1;
        MemAddr    = r_dst;
        MemWData   = r_fill ? r_fill_val : r_hold;
        MemWriteEn = 1'b1;
        if (r_rem == ADDR_W'(1)) w_next = S_DONE;
        else if (r_fill)         w_next = S_WRITE;
        else                     w_next = S_READ;
      end
      S_DONE: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Transfer parameters captured at acceptance, pointer advance and byte holding register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_rem      <= '0;
      r_hold     <= '0;
      r_fill     <= 1'b0;
      r_fill_val <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_src      <= SrcAddr;
            r_dst      <= DstAddr;
            r_rem      <= Len;
            r_fill     <= w_fill_req;
            r_fill_val <= FillValue;
          end
        end
        S_READ: r_hold <= MemRData;
        S_WRITE: begin
          r_src <= r_src + ADDR_W'(1);
          r_dst <= r_dst + ADDR_W'(1);
          r_rem <= r_rem - ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
